pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/sat_counter.sv | 31 +++
 rtl/pipe_stage_skid.sv | 128 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the skid-buffered pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_pkg;

  // Occupancy states of the two-entry stage; the encoding equals the beat count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Default payload width, counter width and bubble value.
  localparam int          DATA_W_DEF    = 64;
  localparam int          CNT_W_DEF     = 16;
  localparam logic [63:0] FLUSH_VAL_DEF = 64'h0;

  // Number of live beats held in a given state.
  function automatic logic [1:0] occ_of(input state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
// Latency: count visible one falling edge after the qualifying cycle.
// Backpressure: none; increments are never lost until saturation.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {CNT_W{1'b1}});

  // Count qualifying cycles, clearing on reset and holding once saturated.
  always_ff @(negedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && !w_at_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with main + skid register and flush support.
// Latency: one clock from accept to out_valid_o when empty; full throughput.
// Backpressure: in_ready_o drops only when both registers hold beats (state decode).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(FLUSH_VAL_DEF),
  parameter int                CNT_W     = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              flush_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_consume;
  logic              w_stall_inc;

  // Handshake flags are pure state decodes so no combinational path
  // exists from out_ready_i to in_ready_o.
  assign w_in_ready  = (r_state != TWO);
  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = in_valid_i && w_in_ready;
  assign w_consume   = w_out_valid && out_ready_i;

  // Next-state and register-load selection; flush overrides every handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush_i) begin
      // Offered beat is dropped even though in_ready_o may be high.
      w_state_nxt = EMPTY;
      w_main_nxt  = FLUSH_VAL;
      w_skid_nxt  = FLUSH_VAL;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_main_nxt  = in_data_i;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            w_main_nxt = in_data_i;
          end else if (w_accept) begin
            w_state_nxt = TWO;
            w_skid_nxt  = in_data_i;
          end else if (w_consume) begin
            // Main keeps its stale value; out_valid_o masks it.
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_consume) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = FLUSH_VAL;
          w_skid_nxt  = FLUSH_VAL;
        end
      endcase
    end
  end

  // State and payload registers update on the falling edge; reset beats flush.
  always_ff @(negedge clk_i) begin
    if (!rst_i) begin
      r_state <= EMPTY;
      r_main  <= FLUSH_VAL;
      r_skid  <= FLUSH_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // A stall is a live output beat held back by downstream, not masked by flush.
  assign w_stall_inc = w_out_valid && !out_ready_i && !flush_i;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign out_data_o  = r_main;
  assign occ_o       = occ_of(r_state);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed table, corner sequences,
// and a randomized valid/ready scoreboard run.
module tb_pipe_stage_skid;

  localparam int          DW = 16;
  localparam int          CW = 4;
  localparam logic [15:0] FV = 16'hDEAD;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic          flush_i = 1'b0;
  logic [1:0]    occ_o;
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(
    .DATA_W    (DW),
    .FLUSH_VAL (FV),
    .CNT_W     (CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .flush_i     (flush_i),
    .occ_o       (occ_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic [1:0]  occ;
    logic [15:0] dat;
    logic [3:0]  st;
    logic [3:0]  fc;
  } vec_t;

  vec_t vec[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, let the falling edge commit, then settle.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [15:0] d, input logic ordy);
    rst_i       = rst;
    flush_i     = fl;
    in_valid_i  = iv;
    in_data_i   = d;
    out_ready_i = ordy;
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] occ, input logic [15:0] dat,
                           input logic [3:0] st, input logic [3:0] fc);
    chk({tag, ".occ"}, 32'(occ_o), 32'(occ));
    chk({tag, ".out_valid"}, 32'(out_valid_o), 32'(occ != 2'd0));
    chk({tag, ".in_ready"}, 32'(in_ready_o), 32'(occ != 2'd2));
    if (occ != 2'd0 || fc != 4'd0 || st != 4'd0 || dat == FV)
      chk({tag, ".data"}, 32'(out_data_o), 32'(dat));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(st));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(fc));
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp_d;
    logic        acc;
    logic        con;
    int          sent;
    int          recv;
    int          cyc;

    //           rst   fl    iv    d        ordy  occ    dat      st     fc
    vec[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'hDEAD, 4'd0, 4'd0};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 16'h000A, 1'b1, 2'd1, 16'h000A, 4'd0, 4'd0};
    vec[2]  = '{1'b1, 1'b0, 1'b1, 16'h000B, 1'b1, 2'd1, 16'h000B, 4'd0, 4'd0};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 16'h000C, 1'b1, 2'd1, 16'h000C, 4'd0, 4'd0};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0, 16'h000C, 4'd0, 4'd0};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 2'd1, 16'h0001, 4'd0, 4'd0};
    vec[6]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 2'd2, 16'h0001, 4'd1, 4'd0};
    vec[7]  = '{1'b1, 1'b0, 1'b1, 16'h0009, 1'b0, 2'd2, 16'h0001, 4'd2, 4'd0};
    vec[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 16'h0002, 4'd2, 4'd0};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 2'd2, 16'h0002, 4'd3, 4'd0};
    vec[10] = '{1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 2'd0, 16'hDEAD, 4'd3, 4'd1};
    vec[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0, 16'hDEAD, 4'd3, 4'd1};
    vec[12] = '{1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 2'd1, 16'h0005, 4'd3, 4'd1};
    vec[13] = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 2'd0, 16'hDEAD, 4'd0, 4'd0};
    vec[14] = '{1'b1, 1'b1, 1'b1, 16'h0007, 1'b1, 2'd0, 16'hDEAD, 4'd0, 4'd1};
    vec[15] = '{1'b1, 1'b0, 1'b1, 16'h0008, 1'b0, 2'd1, 16'h0008, 4'd0, 4'd1};

    // Directed table: each row is one cycle, checked after its falling edge.
    for (int i = 0; i < 16; i++) begin
      cycle(vec[i].rst, vec[i].fl, vec[i].iv, vec[i].d, vec[i].ordy);
      chk_state($sformatf("vec%0d", i), vec[i].occ, vec[i].dat, vec[i].st, vec[i].fc);
    end

    // Stall saturation: stage holds 0x0008 in ONE, downstream never ready.
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk($sformatf("stall_sat%0d", k), 32'(stall_cnt_o), 32'((k < 15) ? k : 15));
    end
    chk("stall_hold.data", 32'(out_data_o), 32'h0008);
    chk("stall_hold.occ", 32'(occ_o), 32'd1);

    // Flush saturation: counter starts at 1, stall count must not move.
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 16'h00F0, 1'b0);
      chk($sformatf("flush_sat%0d", k), 32'(flush_cnt_o), 32'((k + 1 < 15) ? k + 1 : 15));
    end
    chk_state("flush_end", 2'd0, FV, 4'd15, 4'd15);

    // Reset clears saturated counters; then stream at full throughput.
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk_state("rst2", 2'd0, FV, 4'd0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'h00A0 + 16'(k), 1'b1);
      chk($sformatf("stream%0d.occ", k), 32'(occ_o), 32'd1);
      chk($sformatf("stream%0d.data", k), 32'(out_data_o), 32'h00A0 + 32'(k));
    end
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Random valid/ready with a scoreboard: every beat once, in order.
    sent = 0;
    recv = 0;
    cyc  = 0;
    rst_i   = 1'b1;
    flush_i = 1'b0;
    while (recv < 500 && cyc < 5000) begin
      in_valid_i  = (sent < 500) && ($urandom_range(0, 3) != 0);
      in_data_i   = 16'(sent) ^ 16'h5A00;
      out_ready_i = ($urandom_range(0, 2) != 0);
      @(posedge clk_i);
      if (occ_o != 2'(q.size()))
        chk("rand.occ", 32'(occ_o), 32'(q.size()));
      acc = in_valid_i && in_ready_o;
      con = out_valid_o && out_ready_i;
      if (con) begin
        if (q.size() == 0) begin
          chk("rand.spurious", 32'(out_data_o), 32'hFFFF_FFFF);
        end else begin
          exp_d = q.pop_front();
          chk("rand.data", 32'(out_data_o), 32'(exp_d));
          recv++;
        end
      end
      if (acc) begin
        q.push_back(in_data_i);
        sent++;
      end
      @(negedge clk_i);
      #1;
      cyc++;
    end
    chk("rand.delivered", 32'(recv), 32'd500);
    chk("rand.leftover", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
